// File: rtl/parse_action_sequencer.sv
// Parse-action sequencer: issues one latched action per cycle to a shared
// sub-parser and folds the returned values into a 768-bit PHV.
module parse_action_sequencer #(
  parameter int HDR_FIELD_LEN      = 1024,
  parameter int C_PARSE_ACTION_LEN = 13,
  parameter int C_NUM_ACTIONS      = 10,
  parameter int VAL_LEN            = 48
) (
  input  logic                                        axis_clk,
  input  logic                                        aresetn,
  input  logic [HDR_FIELD_LEN-1:0]                    hdr_in,
  input  logic [C_NUM_ACTIONS*C_PARSE_ACTION_LEN-1:0] actions_in,
  input  logic                                        hdr_valid_in,
  output logic                                        hdr_ready_out,
  output logic [HDR_FIELD_LEN-1:0]                    sp_hdr_field,
  output logic                                        sp_hdr_field_valid,
  output logic [C_PARSE_ACTION_LEN-1:0]               sp_parse_action,
  input  logic                                        sp_val_valid,
  input  logic [VAL_LEN-1:0]                          sp_val,
  input  logic [1:0]                                  sp_val_out_select,
  input  logic [2:0]                                  sp_val_seq_select,
  output logic [767:0]                                phv_out,
  output logic                                        phv_valid_out,
  input  logic                                        phv_ready_in
);

  localparam int AW = C_NUM_ACTIONS * C_PARSE_ACTION_LEN;
  localparam logic [4:0] LAST = 5'(C_NUM_ACTIONS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_t;

  state_t                          state_q;
  logic [4:0]                      idx_q;
  logic [AW-1:0]                   act_q;
  logic [HDR_FIELD_LEN-1:0]        hdr_q;
  logic [C_PARSE_ACTION_LEN-1:0]   sp_act_q;
  logic                            sp_vld_q;
  logic                            rdy_q;
  logic                            phv_vld_q;
  logic [767:0]                    phv_q;
  logic [767:0]                    phv_d;
  logic                            acc;
  logic                            cap;

  assign hdr_ready_out      = rdy_q;
  assign sp_hdr_field       = hdr_q;
  assign sp_hdr_field_valid = sp_vld_q;
  assign sp_parse_action    = sp_act_q;
  assign phv_out            = phv_q;
  assign phv_valid_out      = phv_vld_q;

  // Results trail issue by one cycle: window is ISSUE index>=1 plus DRAIN.
  always_comb begin
    acc   = hdr_valid_in & rdy_q;
    cap   = sp_val_valid &
            (((state_q == ISSUE) && (idx_q != 5'd0)) ||
             (state_q == DRAIN));
    phv_d = phv_q;
    if (acc) begin
      phv_d = '0;
    end else if (cap) begin
      case (sp_val_out_select)
        2'b01: phv_d[16*int'(sp_val_seq_select) +: 16] =
                 sp_val[15:0];
        2'b10: phv_d[128+32*int'(sp_val_seq_select) +: 32] =
                 sp_val[31:0];
        2'b11: phv_d[384+48*int'(sp_val_seq_select) +: VAL_LEN] =
                 sp_val;
        default: ;
      endcase
    end
  end

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      act_q     <= '0;
      hdr_q     <= '0;
      sp_act_q  <= '0;
      sp_vld_q  <= 1'b0;
      rdy_q     <= 1'b0;
      phv_vld_q <= 1'b0;
      phv_q     <= '0;
    end else begin
      phv_q <= phv_d;
      unique case (state_q)
        IDLE: begin
          rdy_q <= 1'b1;
          if (acc) begin
            hdr_q    <= hdr_in;
            sp_act_q <= actions_in[C_PARSE_ACTION_LEN-1:0];
            act_q    <= actions_in >> C_PARSE_ACTION_LEN;
            sp_vld_q <= 1'b1;
            idx_q    <= '0;
            rdy_q    <= 1'b0;
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          idx_q    <= idx_q + 5'd1;
          sp_act_q <= act_q[C_PARSE_ACTION_LEN-1:0];
          act_q    <= act_q >> C_PARSE_ACTION_LEN;
          if (idx_q == LAST) begin
            sp_vld_q <= 1'b0;
            sp_act_q <= '0;
            state_q  <= DRAIN;
          end
        end
        DRAIN: begin
          phv_vld_q <= 1'b1;
          state_q   <= OUT;
        end
        OUT: begin
          if (phv_ready_in) begin
            phv_vld_q <= 1'b0;
            rdy_q     <= 1'b1;
            idx_q     <= '0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parse_action_sequencer.sv
// Bench for parse_action_sequencer: behavioural sub-parser plus a PHV
// scoreboard built from the action list, checked on every output cycle.
module tb_parse_action_sequencer;

  localparam int N  = 10;
  localparam int AW = N * 13;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [1023:0]  hdr_in;
  logic [AW-1:0]  actions_in;
  logic           hdr_valid_in;
  logic           hdr_ready_out;
  logic [1023:0]  sp_hdr_field;
  logic           sp_hdr_field_valid;
  logic [12:0]    sp_parse_action;
  logic           sp_val_valid;
  logic [47:0]    sp_val;
  logic [1:0]     sp_val_out_select;
  logic [2:0]     sp_val_seq_select;
  logic [767:0]   phv_out;
  logic           phv_valid_out;
  logic           phv_ready_in;

  logic           sub_v;
  logic [1:0]     sub_sel;
  logic [2:0]     sub_seq;
  logic [47:0]    sub_val;
  logic           stray_en;

  int nvec = 0;
  int nerr = 0;
  int issue_cnt = 0;
  logic [767:0] exp_q[$];

  always #5 clk = ~clk;

  parse_action_sequencer dut (
    .axis_clk(clk), .aresetn(rst_n),
    .hdr_in(hdr_in), .actions_in(actions_in),
    .hdr_valid_in(hdr_valid_in), .hdr_ready_out(hdr_ready_out),
    .sp_hdr_field(sp_hdr_field),
    .sp_hdr_field_valid(sp_hdr_field_valid),
    .sp_parse_action(sp_parse_action),
    .sp_val_valid(sp_val_valid), .sp_val(sp_val),
    .sp_val_out_select(sp_val_out_select),
    .sp_val_seq_select(sp_val_seq_select),
    .phv_out(phv_out), .phv_valid_out(phv_valid_out),
    .phv_ready_in(phv_ready_in)
  );

  function automatic logic [7:0] byte_at(input logic [1023:0] h,
                                         input int k);
    return (k < 128) ? h[8*k +: 8] : 8'h00;
  endfunction

  // Action: [12:6] byte offset, [5:4] width (00/01=2B,10=4B,11=6B),
  // [3:1] container index, [0] valid. Returns {sel, seq, value}.
  function automatic logic [52:0] decode(input logic [1023:0] h,
                                         input logic [12:0] a);
    logic [47:0] v;
    logic [1:0]  sel;
    int          nb;
    int          off;
    off = int'(a[12:6]);
    if (!a[0]) sel = 2'b00;
    else if (a[5:4] == 2'b00) sel = 2'b01;
    else sel = a[5:4];
    nb = (sel == 2'b01) ? 2 : (sel == 2'b10) ? 4 : 6;
    v = '0;
    for (int i = 0; i < nb; i++) v = {v[39:0], byte_at(h, off + i)};
    return {sel, a[3:1], v};
  endfunction

  function automatic logic [767:0] model_phv(input logic [1023:0] h,
                                             input logic [AW-1:0] acts);
    logic [767:0] p;
    logic [52:0]  r;
    int           s;
    p = '0;
    for (int k = 0; k < N; k++) begin
      r = decode(h, acts[13*k +: 13]);
      s = int'(r[50:48]);
      case (r[52:51])
        2'b01: p[16*s +: 16] = r[15:0];
        2'b10: p[128 + 32*s +: 32] = r[31:0];
        2'b11: p[384 + 48*s +: 48] = r[47:0];
        default: ;
      endcase
    end
    return p;
  endfunction

  function automatic logic [12:0] mk(input int off, input int ty,
                                     input int seq, input bit v);
    return {7'(off), 2'(ty), 3'(seq), v};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_v <= 1'b0; sub_sel <= '0; sub_seq <= '0; sub_val <= '0;
    end else begin
      sub_v <= sp_hdr_field_valid;
      {sub_sel, sub_seq, sub_val} <= decode(sp_hdr_field, sp_parse_action);
    end
  end

  assign sp_val_valid      = sub_v | stray_en;
  assign sp_val            = stray_en ? 48'hFFFF_FFFF_FFFF : sub_val;
  assign sp_val_out_select = stray_en ? 2'b11 : sub_sel;
  assign sp_val_seq_select = stray_en ? 3'd0 : sub_seq;

  task automatic chk(input string nm, input logic [767:0] a,
                     input logic [767:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", nm, a, e);
    end
  endtask

  task automatic chk_int(input string nm, input int a, input int e);
    nvec++;
    if (a != e) begin
      nerr++;
      $display("FAIL %s got=%0d exp=%0d", nm, a, e);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (sp_hdr_field_valid) issue_cnt++;
  end

  logic         pv = 1'b0;
  logic         pr = 1'b0;
  logic [767:0] pphv = '0;
  logic [767:0] last_phv = '0;

  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      pv = 1'b0; pr = 1'b0; last_phv = '0;
    end else begin
      if (pv && !pr) begin
        chk_int("hold_valid", int'(phv_valid_out), 1);
        chk("hold_phv", phv_out, pphv);
      end
      if (phv_valid_out) chk_int("busy_ready", int'(hdr_ready_out), 0);
      if (phv_valid_out && phv_ready_in) begin
        if (exp_q.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL unexpected_phv got=%0h exp=none", phv_out);
        end else begin
          chk("phv", phv_out, exp_q.pop_front());
        end
        last_phv = phv_out;
      end
      if (hdr_ready_out) chk("idle_phv", phv_out, last_phv);
      pv = phv_valid_out; pr = phv_ready_in; pphv = phv_out;
    end
  end

  time acc_t;
  time prev_acc;

  // Called at a negedge; returns at the negedge after the OUT handshake.
  task automatic send(input logic [1023:0] h, input logic [AW-1:0] a,
                      input int hold);
    int w;
    int cyc;
    int ic0;
    w = 0;
    while (!hdr_ready_out && w < 200) begin @(negedge clk); w++; end
    chk_int("accept_wait", int'(w < 200), 1);
    hdr_in = h; actions_in = a; hdr_valid_in = 1'b1;
    exp_q.push_back(model_phv(h, a));
    if (hold > 0) phv_ready_in = 1'b0;
    @(posedge clk);
    prev_acc = acc_t; acc_t = $time; ic0 = issue_cnt;
    #1 hdr_valid_in = 1'b0;
    cyc = 0;
    do begin @(negedge clk); cyc++; end
    while (!phv_valid_out && cyc < 200);
    chk_int("latency", cyc, N + 2);
    for (int i = 0; i < hold; i++) begin
      hdr_valid_in = 1'b1; hdr_in = ~h; stray_en = 1'b1;
      chk_int("hold_ready", int'(hdr_ready_out), 0);
      @(negedge clk);
    end
    hdr_valid_in = 1'b0; stray_en = 1'b0; phv_ready_in = 1'b1;
    @(negedge clk);
    chk_int("issue_cycles", issue_cnt - ic0, N);
  endtask

  logic [1023:0] h;
  logic [AW-1:0] a;
  logic [767:0]  lit;
  int            saw;

  initial begin
    rst_n = 1'b0; hdr_in = '0; actions_in = '0; hdr_valid_in = 1'b0;
    phv_ready_in = 1'b1; stray_en = 1'b0; acc_t = 0; prev_acc = 0;
    @(negedge clk);
    chk_int("rst_ready", int'(hdr_ready_out), 0);
    chk_int("rst_valid", int'(phv_valid_out), 0);
    chk("rst_phv", phv_out, '0);
    rst_n = 1'b1;
    #1 chk_int("rel_ready0", int'(hdr_ready_out), 0);
    @(negedge clk);
    chk_int("rel_ready1", int'(hdr_ready_out), 1);

    h = '0; h[15:8] = 8'hAB; h[23:16] = 8'hCD;
    a = '0; a[12:0] = 13'h0043;
    lit = '0; lit[31:16] = 16'hABCD;
    chk("model_034", model_phv(h, a), lit);
    send(h, a, 0);

    for (int k = 0; k < 128; k++) h[8*k +: 8] = 8'(k + 1);
    for (int k = 0; k < N; k++) a[13*k +: 13] = 13'h0042;
    a[0 +: 13] = mk(4, 2, 0, 1);
    a[65 +: 13] = mk(10, 3, 7, 1);
    lit = '0; lit[159:128] = 32'h0506_0708;
    lit[767:720] = 48'h0B0C_0D0E_0F10;
    chk("model_035", model_phv(h, a), lit);
    send(h, a, 0);

    for (int k = 0; k < N; k++) a[13*k +: 13] = 13'h0000;
    a[26 +: 13] = mk(2, 0, 3, 1);
    a[91 +: 13] = mk(20, 0, 3, 1);
    lit = '0; lit[63:48] = 16'h1516;
    chk("model_036", model_phv(h, a), lit);
    send(h, a, 0);
    chk_int("b2b_spacing", int'((acc_t - prev_acc) / 10), N + 3);

    stray_en = 1'b1;
    repeat (3) @(negedge clk);
    stray_en = 1'b0;

    for (int k = 0; k < N; k++) a[13*k +: 13] = mk(3*k, k % 4, k % 8, 1);
    send(h, a, 5);

    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 32; k++) h[32*k +: 32] = $urandom;
      for (int k = 0; k < N; k++) a[13*k +: 13] = 13'($urandom);
      send(h, a, p);
    end

    for (int k = 0; k < N; k++) a[13*k +: 13] = mk(k, 1, k % 8, 1);
    hdr_in = h; actions_in = a; hdr_valid_in = 1'b1;
    @(posedge clk);
    #1 hdr_valid_in = 1'b0;
    repeat (5) @(negedge clk);
    chk_int("mid_issue_vld", int'(sp_hdr_field_valid), 1);
    chk_int("mid_issue_act", int'(sp_parse_action), int'(a[52 +: 13]));
    rst_n = 1'b0;
    #1;
    chk_int("arst_ready", int'(hdr_ready_out), 0);
    chk_int("arst_spvld", int'(sp_hdr_field_valid), 0);
    chk_int("arst_spact", int'(sp_parse_action), 0);
    chk_int("arst_sphdr", int'(|sp_hdr_field), 0);
    chk("arst_phv", phv_out, '0);
    chk_int("arst_valid", int'(phv_valid_out), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    saw = 0;
    repeat (20) begin
      @(negedge clk);
      if (phv_valid_out) saw++;
    end
    chk_int("abandoned", saw, 0);
    send(h, a, 0);

    repeat (3) @(negedge clk);
    chk_int("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
